// File: rtl/timers_t1_sfr_bank_if.sv
// -----------------------------------------------------------------------------
// timers_t1_sfr_bank_if
//   CPU SFR bus between the CPU (master) and the Timer 1 SFR bank (slave).
//
//   Handshake: timers_sfr_wr_i and timers_sfr_rd_i are single-cycle strobes
//   qualified by timers_sfr_addr_i; there is no ready/back-pressure. A read
//   strobe in cycle N returns timers_sfr_rdata_o/timers_sfr_rhit_o registered
//   in cycle N+1 (rhit=1 means the address belongs to this bank). A write
//   strobe takes effect at the edge that ends the strobe cycle.
//
//   Signals (names keep the bank-side direction suffixes):
//     timers_sfr_addr_i   [7:0]  SFR address
//     timers_sfr_wr_i            write strobe
//     timers_sfr_rd_i            read strobe
//     timers_sfr_wdata_i  [7:0]  write data
//     timers_sfr_rdata_o  [7:0]  read data, registered
//     timers_sfr_rhit_o          read data valid / address hit, registered
// -----------------------------------------------------------------------------
interface timers_t1_sfr_bank_if;
  logic [7:0] timers_sfr_addr_i;
  logic       timers_sfr_wr_i;
  logic       timers_sfr_rd_i;
  logic [7:0] timers_sfr_wdata_i;
  logic [7:0] timers_sfr_rdata_o;
  logic       timers_sfr_rhit_o;

  modport master (
    output timers_sfr_addr_i,
    output timers_sfr_wr_i,
    output timers_sfr_rd_i,
    output timers_sfr_wdata_i,
    input  timers_sfr_rdata_o,
    input  timers_sfr_rhit_o
  );

  modport slave (
    input  timers_sfr_addr_i,
    input  timers_sfr_wr_i,
    input  timers_sfr_rd_i,
    input  timers_sfr_wdata_i,
    output timers_sfr_rdata_o,
    output timers_sfr_rhit_o
  );
endinterface

// File: rtl/timers_t1_sfr_bank.sv
// -----------------------------------------------------------------------------
// timers_t1_sfr_bank
//   SFR storage and CPU bus front end for the Timer 1 24-bit counter core.
//   Holds TF1, TR1 and TMOD[7:4], merges CPU byte writes into the count that
//   the core feeds back, synchronises the INT1 pin and raises the Timer 1 IRQ.
//
//   Ports:
//     timers_clock_i, timers_reset_i_b   clock, synchronous active-low reset
//     sfr_bus (slave modport)            CPU SFR bus (addr/wr/rd/wdata/rdata/rhit)
//     timers_int1_pin_i                  asynchronous INT1 pin
//     timers_irq_ack_t1_i                interrupt vector acknowledge
//     timers_irq_t1_o                    interrupt request (= TF1)
//     timers_t1_{th1,tm1,tl1}_fb_i       core count feedback
//     timers_t1_tf1_fb_i                 core TF1 feedback
//     timers_sfr_{th1,tm1,tl1}_o         merged count to core (combinational)
//     timers_sfr_tcon_tf1_o/_tr1_o       TF1 / TR1 to core
//     timers_sfr_tmod_gate_t1_o/_m1t1_o/_m0t1_o  TMOD bits 7/5/4 to core
//     timers_int1_o                      synchronised INT1 to core
//
//   Build option: define TIMERS_T1_READ_LATCH_EN to snapshot TM1/TH1 on a TL1
//   read so that TL1, TM1, TH1 read back as one atomic 24-bit value.
// -----------------------------------------------------------------------------
module timers_t1_sfr_bank #(
  parameter logic [7:0] ADDR_TCON = 8'h88,
  parameter logic [7:0] ADDR_TMOD = 8'h89,
  parameter logic [7:0] ADDR_TL1  = 8'h8B,
  parameter logic [7:0] ADDR_TM1  = 8'h8E,
  parameter logic [7:0] ADDR_TH1  = 8'h8D
) (
  input  logic                      timers_clock_i,
  input  logic                      timers_reset_i_b,
  timers_t1_sfr_bank_if.slave       sfr_bus,
  input  logic                      timers_int1_pin_i,
  input  logic                      timers_irq_ack_t1_i,
  output logic                      timers_irq_t1_o,
  input  logic [7:0]                timers_t1_th1_fb_i,
  input  logic [7:0]                timers_t1_tm1_fb_i,
  input  logic [7:0]                timers_t1_tl1_fb_i,
  input  logic                      timers_t1_tf1_fb_i,
  output logic [7:0]                timers_sfr_th1_o,
  output logic [7:0]                timers_sfr_tm1_o,
  output logic [7:0]                timers_sfr_tl1_o,
  output logic                      timers_sfr_tcon_tf1_o,
  output logic                      timers_sfr_tcon_tr1_o,
  output logic                      timers_sfr_tmod_gate_t1_o,
  output logic                      timers_sfr_tmod_m1t1_o,
  output logic                      timers_sfr_tmod_m0t1_o,
  output logic                      timers_int1_o
);

  logic [7:0] addr;
  logic [7:0] wdata;
  logic       wr;
  logic       rd;

  assign addr  = sfr_bus.timers_sfr_addr_i;
  assign wdata = sfr_bus.timers_sfr_wdata_i;
  assign wr    = sfr_bus.timers_sfr_wr_i;
  assign rd    = sfr_bus.timers_sfr_rd_i;

  // Write decode
  logic wr_tcon, wr_tmod, wr_tl1, wr_tm1, wr_th1;

  assign wr_tcon = wr && (addr == ADDR_TCON);
  assign wr_tmod = wr && (addr == ADDR_TMOD);
  assign wr_tl1  = wr && (addr == ADDR_TL1);
  assign wr_tm1  = wr && (addr == ADDR_TM1);
  assign wr_th1  = wr && (addr == ADDR_TH1);

  // Count merge: the core registers these, so a CPU byte write replaces the
  // feedback byte for one cycle and the core counts from the merged value.
  assign timers_sfr_tl1_o = wr_tl1 ? wdata : timers_t1_tl1_fb_i;
  assign timers_sfr_tm1_o = wr_tm1 ? wdata : timers_t1_tm1_fb_i;
  assign timers_sfr_th1_o = wr_th1 ? wdata : timers_t1_th1_fb_i;

  // Control state
  logic       tf1_q;
  logic       tf1_d;
  logic       tr1_q;
  logic [3:0] tmod_q;       // TMOD[7:4]: GATE, C/T, M1, M0
  logic       int1_meta_q;
  logic       int1_sync_q;
  logic [7:0] rdata_q;
  logic       rhit_q;

  // TF1 next state. A rising core TF1 (fb high while our copy is low) is a
  // fresh overflow and wins over both a CPU clear and an acknowledge, so an
  // overflow landing in the same cycle as either is never lost.
  always_comb begin
    tf1_d = timers_t1_tf1_fb_i;
    if (timers_t1_tf1_fb_i && !tf1_q) begin
      tf1_d = 1'b1;
    end else if (wr_tcon) begin
      tf1_d = wdata[7];
    end else if (timers_irq_ack_t1_i) begin
      tf1_d = 1'b0;
    end
  end

  // Read path. TM1/TH1 come either live from the core or from the snapshot.
  logic [7:0] tm1_rd;
  logic [7:0] th1_rd;

`ifdef TIMERS_T1_READ_LATCH_EN
  logic [15:0] shadow_q;    // {TH1, TM1} captured on a TL1 read

  always_ff @(posedge timers_clock_i) begin
    if (!timers_reset_i_b) begin
      shadow_q <= 16'h0000;
    end else if (rd && (addr == ADDR_TL1)) begin
      shadow_q <= {timers_t1_th1_fb_i, timers_t1_tm1_fb_i};
    end
  end

  assign tm1_rd = shadow_q[7:0];
  assign th1_rd = shadow_q[15:8];
`else
  assign tm1_rd = timers_t1_tm1_fb_i;
  assign th1_rd = timers_t1_th1_fb_i;
`endif

  logic       rd_hit;
  logic [7:0] rd_data;

  // Read mux uses pre-edge state, so a read and write to the same address in
  // one cycle return the value before the write.
  always_comb begin
    rd_hit  = 1'b1;
    rd_data = 8'h00;
    case (addr)
      ADDR_TCON: rd_data = {tf1_q, tr1_q, 6'b000000};
      ADDR_TMOD: rd_data = {tmod_q, 4'b0000};
      ADDR_TL1:  rd_data = timers_t1_tl1_fb_i;
      ADDR_TM1:  rd_data = tm1_rd;
      ADDR_TH1:  rd_data = th1_rd;
      default:   rd_hit  = 1'b0;
    endcase
  end

  always_ff @(posedge timers_clock_i) begin
    if (!timers_reset_i_b) begin
      tf1_q       <= 1'b0;
      tr1_q       <= 1'b0;
      tmod_q      <= 4'h0;
      int1_meta_q <= 1'b0;
      int1_sync_q <= 1'b0;
      rdata_q     <= 8'h00;
      rhit_q      <= 1'b0;
    end else begin
      tf1_q       <= tf1_d;
      int1_meta_q <= timers_int1_pin_i;
      int1_sync_q <= int1_meta_q;
      if (wr_tcon) begin
        tr1_q <= wdata[6];
      end
      if (wr_tmod) begin
        tmod_q <= wdata[7:4];
      end
      if (rd && rd_hit) begin
        rdata_q <= rd_data;
        rhit_q  <= 1'b1;
      end else begin
        rdata_q <= 8'h00;
        rhit_q  <= 1'b0;
      end
    end
  end

  assign sfr_bus.timers_sfr_rdata_o = rdata_q;
  assign sfr_bus.timers_sfr_rhit_o  = rhit_q;

  assign timers_irq_t1_o           = tf1_q;
  assign timers_sfr_tcon_tf1_o     = tf1_q;
  assign timers_sfr_tcon_tr1_o     = tr1_q;
  assign timers_sfr_tmod_gate_t1_o = tmod_q[3];
  assign timers_sfr_tmod_m1t1_o    = tmod_q[1];
  assign timers_sfr_tmod_m0t1_o    = tmod_q[0];
  assign timers_int1_o             = int1_sync_q;

endmodule

// File: tb/tb_timers_t1_sfr_bank.sv
// -----------------------------------------------------------------------------
// tb_timers_t1_sfr_bank
//   Directed bench for the Timer 1 SFR bank. A small behavioural counter core
//   closes the loop: it registers the merged count, increments it when
//   TR1 && (!GATE || INT1), and reports TF1 as the bank's TF1 OR'ed with an
//   overflow happening in the current cycle.
// -----------------------------------------------------------------------------
module tb_timers_t1_sfr_bank;

  localparam logic [7:0] A_TCON = 8'h88;
  localparam logic [7:0] A_TMOD = 8'h89;
  localparam logic [7:0] A_TL1  = 8'h8B;
  localparam logic [7:0] A_TM1  = 8'h8E;
  localparam logic [7:0] A_TH1  = 8'h8D;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  timers_t1_sfr_bank_if bus ();

  logic       pin;
  logic       ack;
  logic       irq;
  logic [7:0] th1_fb, tm1_fb, tl1_fb;
  logic       tf1_fb;
  logic [7:0] th1_o, tm1_o, tl1_o;
  logic       tf1_o, tr1_o, gate_o, m1_o, m0_o, int1_o;

  timers_t1_sfr_bank dut (
    .timers_clock_i            (clk),
    .timers_reset_i_b          (rst_b),
    .sfr_bus                   (bus),
    .timers_int1_pin_i         (pin),
    .timers_irq_ack_t1_i       (ack),
    .timers_irq_t1_o           (irq),
    .timers_t1_th1_fb_i        (th1_fb),
    .timers_t1_tm1_fb_i        (tm1_fb),
    .timers_t1_tl1_fb_i        (tl1_fb),
    .timers_t1_tf1_fb_i        (tf1_fb),
    .timers_sfr_th1_o          (th1_o),
    .timers_sfr_tm1_o          (tm1_o),
    .timers_sfr_tl1_o          (tl1_o),
    .timers_sfr_tcon_tf1_o     (tf1_o),
    .timers_sfr_tcon_tr1_o     (tr1_o),
    .timers_sfr_tmod_gate_t1_o (gate_o),
    .timers_sfr_tmod_m1t1_o    (m1_o),
    .timers_sfr_tmod_m0t1_o    (m0_o),
    .timers_int1_o             (int1_o)
  );

  // ---------------- core model ----------------
  logic [23:0] cnt_q;
  logic        ld_en;
  logic [23:0] ld_val;
  logic [23:0] merged;
  logic        run;
  logic        ovf;
  logic [23:0] count;

  assign merged = {th1_o, tm1_o, tl1_o};
  assign run    = tr1_o && (!gate_o || int1_o);
  assign ovf    = run && (merged == 24'hFFFFFF);
  assign tf1_fb = tf1_o | ovf;
  assign {th1_fb, tm1_fb, tl1_fb} = cnt_q;
  assign count  = merged;

  always @(posedge clk) begin
    if (!rst_b)     cnt_q <= 24'h000000;
    else if (ld_en) cnt_q <= ld_val;
    else            cnt_q <= merged + {23'd0, run};
  end

  // ---------------- bookkeeping ----------------
  int n_vec;
  int n_err;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    bus.timers_sfr_addr_i  = a;
    bus.timers_sfr_wdata_i = d;
    bus.timers_sfr_wr_i    = 1'b1;
    step();
    bus.timers_sfr_wr_i    = 1'b0;
  endtask

  task automatic cpu_rd(input logic [7:0] a);
    bus.timers_sfr_addr_i = a;
    bus.timers_sfr_rd_i   = 1'b1;
    step();
    bus.timers_sfr_rd_i   = 1'b0;
  endtask

  task automatic core_load(input logic [23:0] v);
    ld_en  = 1'b1;
    ld_val = v;
    step();
    ld_en  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_b = 1'b0;
    step();
    step();
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL por_irq: got %b want 0", irq); end
    n_vec++; if ({tr1_o, gate_o, m1_o, m0_o} !== 4'b0000) begin n_err++; $display("FAIL por_ctrl: got %b want 0000", {tr1_o, gate_o, m1_o, m0_o}); end
    rst_b = 1'b1;
    cpu_wr(A_TCON, 8'h80);
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL tcon_set_tf1: got %b want 1", irq); end
    core_load(24'hABCDEF);
    n_vec++; if (count !== 24'hABCDEF) begin n_err++; $display("FAIL fb_pass: got %h want abcdef", count); end
    cpu_rd(A_TL1);
    n_vec++; if ({bus.timers_sfr_rhit_o, bus.timers_sfr_rdata_o} !== 9'h1EF) begin n_err++; $display("FAIL rd_tl1_pre: got %h want 1ef", {bus.timers_sfr_rhit_o, bus.timers_sfr_rdata_o}); end
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    n_vec++; if ({irq, tr1_o} !== 2'b00) begin n_err++; $display("FAIL rst_irq_tr1: got %b want 00", {irq, tr1_o}); end
    n_vec++; if ({bus.timers_sfr_rhit_o, bus.timers_sfr_rdata_o} !== 9'h000) begin n_err++; $display("FAIL rst_rdata: got %h want 000", {bus.timers_sfr_rhit_o, bus.timers_sfr_rdata_o}); end
    n_vec++; if (count !== 24'h000000) begin n_err++; $display("FAIL rst_count: got %h want 000000", count); end
  endtask

  task automatic test_overflow();
    cpu_wr(A_TMOD, 8'h00);
    cpu_wr(A_TL1, 8'hFE);
    cpu_wr(A_TM1, 8'hFF);
    cpu_wr(A_TH1, 8'hFF);
    n_vec++; if (count !== 24'hFFFFFE) begin n_err++; $display("FAIL byte_writes: got %h want fffffe", count); end
    cpu_wr(A_TCON, 8'h40);
    n_vec++; if ({tr1_o, irq} !== 2'b10) begin n_err++; $display("FAIL tr1_set: got %b want 10", {tr1_o, irq}); end
    step();
    n_vec++; if ({irq, count} !== {1'b0, 24'hFFFFFF}) begin n_err++; $display("FAIL pre_wrap: got %h want 0ffffff", {irq, count}); end
    step();
    n_vec++; if ({irq, count} !== {1'b1, 24'h000000}) begin n_err++; $display("FAIL wrap_irq: got %h want 1000000", {irq, count}); end
  endtask

  task automatic test_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL ack_clear: got %b want 0", irq); end
    // overflow in the same cycle as ack: overflow wins
    core_load(24'hFFFFFF);
    ack = 1'b1;
    step();
    ack = 1'b0;
    n_vec++; if ({irq, count} !== {1'b1, 24'h000000}) begin n_err++; $display("FAIL ovf_vs_ack: got %h want 1000000", {irq, count}); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL ack_clear2: got %b want 0", irq); end
    // overflow in the same cycle as a TCON write of TF1=0
    core_load(24'hFFFFFF);
    cpu_wr(A_TCON, 8'h40);
    n_vec++; if ({irq, tr1_o} !== 2'b11) begin n_err++; $display("FAIL ovf_vs_tcon0: got %b want 11", {irq, tr1_o}); end
    step();
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL tf1_hold: got %b want 1", irq); end
  endtask

  task automatic test_merge();
    core_load(24'h123456);
    bus.timers_sfr_addr_i  = A_TL1;
    bus.timers_sfr_wdata_i = 8'h10;
    bus.timers_sfr_wr_i    = 1'b1;
    #1;
    n_vec++; if ({th1_o, tm1_o, tl1_o} !== 24'h123410) begin n_err++; $display("FAIL merge_comb: got %h want 123410", {th1_o, tm1_o, tl1_o}); end
    step();
    bus.timers_sfr_wr_i = 1'b0;
    #1;
    n_vec++; if (count !== 24'h123411) begin n_err++; $display("FAIL merge_count: got %h want 123411", count); end
  endtask

  task automatic test_gate();
    cpu_wr(A_TCON, 8'h40);
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL tcon_clr_tf1: got %b want 0", irq); end
    cpu_wr(A_TMOD, 8'h80);
    n_vec++; if ({gate_o, m1_o, m0_o} !== 3'b100) begin n_err++; $display("FAIL tmod_gate: got %b want 100", {gate_o, m1_o, m0_o}); end
    core_load(24'h000100);
    step();
    step();
    n_vec++; if (count !== 24'h000100) begin n_err++; $display("FAIL gate_frozen: got %h want 000100", count); end
    pin = 1'b1;
    step();
    n_vec++; if (int1_o !== 1'b0) begin n_err++; $display("FAIL int1_lat1: got %b want 0", int1_o); end
    step();
    n_vec++; if ({int1_o, count} !== {1'b1, 24'h000100}) begin n_err++; $display("FAIL int1_lat2: got %h want 1000100", {int1_o, count}); end
    step();
    n_vec++; if (count !== 24'h000101) begin n_err++; $display("FAIL gate_run: got %h want 000101", count); end
  endtask

  task automatic test_read();
    pin = 1'b0;
    cpu_wr(A_TCON, 8'h00);
    core_load(24'h120000);
    cpu_rd(A_TH1);
    n_vec++; if ({bus.timers_sfr_rhit_o, bus.timers_sfr_rdata_o} !== 9'h112) begin n_err++; $display("FAIL rd_th1: got %h want 112", {bus.timers_sfr_rhit_o, bus.timers_sfr_rdata_o}); end
    cpu_rd(8'h90);
    n_vec++; if ({bus.timers_sfr_rhit_o, bus.timers_sfr_rdata_o} !== 9'h000) begin n_err++; $display("FAIL rd_miss: got %h want 000", {bus.timers_sfr_rhit_o, bus.timers_sfr_rdata_o}); end
    cpu_wr(A_TMOD, 8'h5F);
    n_vec++; if ({gate_o, m1_o, m0_o} !== 3'b001) begin n_err++; $display("FAIL tmod_5f: got %b want 001", {gate_o, m1_o, m0_o}); end
    cpu_rd(A_TMOD);
    n_vec++; if ({bus.timers_sfr_rhit_o, bus.timers_sfr_rdata_o} !== 9'h150) begin n_err++; $display("FAIL rd_tmod: got %h want 150", {bus.timers_sfr_rhit_o, bus.timers_sfr_rdata_o}); end
    // read and write of the same address in one cycle
    bus.timers_sfr_rd_i = 1'b1;
    cpu_wr(A_TMOD, 8'hA0);
    bus.timers_sfr_rd_i = 1'b0;
    n_vec++; if ({bus.timers_sfr_rhit_o, bus.timers_sfr_rdata_o} !== 9'h150) begin n_err++; $display("FAIL rd_wr_same: got %h want 150", {bus.timers_sfr_rhit_o, bus.timers_sfr_rdata_o}); end
    n_vec++; if ({gate_o, m1_o, m0_o} !== 3'b110) begin n_err++; $display("FAIL tmod_a0: got %b want 110", {gate_o, m1_o, m0_o}); end
    cpu_wr(8'h90, 8'hFF);
    cpu_rd(A_TMOD);
    n_vec++; if (bus.timers_sfr_rdata_o !== 8'hA0) begin n_err++; $display("FAIL unowned_tmod: got %h want a0", bus.timers_sfr_rdata_o); end
    cpu_rd(A_TCON);
    n_vec++; if ({bus.timers_sfr_rhit_o, bus.timers_sfr_rdata_o} !== 9'h100) begin n_err++; $display("FAIL unowned_tcon: got %h want 100", {bus.timers_sfr_rhit_o, bus.timers_sfr_rdata_o}); end
    cpu_wr(A_TCON, 8'hFF);
    cpu_rd(A_TCON);
    n_vec++; if (bus.timers_sfr_rdata_o !== 8'hC0) begin n_err++; $display("FAIL rd_tcon_ff: got %h want c0", bus.timers_sfr_rdata_o); end
    cpu_wr(A_TCON, 8'h00);
  endtask

  task automatic test_read_latch();
    logic [7:0] exp_tm1;
    logic [7:0] exp_th1;
`ifdef TIMERS_T1_READ_LATCH_EN
    exp_tm1 = 8'hFF;
    exp_th1 = 8'h00;
`else
    exp_tm1 = 8'h00;
    exp_th1 = 8'h01;
`endif
    cpu_wr(A_TMOD, 8'h00);
    cpu_wr(A_TCON, 8'h40);
    core_load(24'h00FFFF);
    cpu_rd(A_TL1);
    n_vec++; if (bus.timers_sfr_rdata_o !== 8'hFF) begin n_err++; $display("FAIL latch_tl1: got %h want ff", bus.timers_sfr_rdata_o); end
    cpu_rd(A_TM1);
    n_vec++; if (bus.timers_sfr_rdata_o !== exp_tm1) begin n_err++; $display("FAIL latch_tm1: got %h want %h", bus.timers_sfr_rdata_o, exp_tm1); end
    cpu_rd(A_TH1);
    n_vec++; if (bus.timers_sfr_rdata_o !== exp_th1) begin n_err++; $display("FAIL latch_th1: got %h want %h", bus.timers_sfr_rdata_o, exp_th1); end
  endtask

  task automatic test_reset_mid();
    cpu_wr(A_TMOD, 8'hB0);
    cpu_wr(A_TCON, 8'hC0);
    pin = 1'b1;
    step();
    step();
    n_vec++; if ({irq, int1_o, gate_o} !== 3'b111) begin n_err++; $display("FAIL pre_rst_state: got %b want 111", {irq, int1_o, gate_o}); end
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    n_vec++; if ({irq, tr1_o, gate_o, m1_o, m0_o, int1_o} !== 6'b000000) begin n_err++; $display("FAIL mid_rst_ctrl: got %b want 000000", {irq, tr1_o, gate_o, m1_o, m0_o, int1_o}); end
    n_vec++; if (count !== 24'h000000) begin n_err++; $display("FAIL mid_rst_count: got %h want 000000", count); end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "timeout");
  end

  // ---------------- sequence + report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    rst_b = 1'b0;
    pin   = 1'b0;
    ack   = 1'b0;
    ld_en = 1'b0;
    ld_val = 24'h000000;
    bus.timers_sfr_addr_i  = 8'h00;
    bus.timers_sfr_wr_i    = 1'b0;
    bus.timers_sfr_rd_i    = 1'b0;
    bus.timers_sfr_wdata_i = 8'h00;

    test_reset();
    test_overflow();
    test_ack();
    test_merge();
    test_gate();
    test_read();
    test_read_latch();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/timers_t1_sfr_bank.md
Name: timers_t1_sfr_bank

Overview:
- SFR storage and bus interface that sits directly upstream of the Timer 1 24-bit counter core and feeds its count, TMOD, TCON and INT1 inputs.
- Holds the Timer 1 control bits and TF1, and merges CPU byte writes into the count fed back from the core's registered outputs.
- Synchronises the external INT1 pin, serves CPU reads, and raises the Timer 1 interrupt request to the interrupt controller.

Parameters:
- ADDR_TCON, 8'h88, SFR address of TCON (bank owns bits 7:6 only)
- ADDR_TMOD, 8'h89, SFR address of TMOD (bank owns bits 7:4 only)
- ADDR_TL1, 8'h8B, SFR address of count bits 7:0
- ADDR_TM1, 8'h8E, SFR address of count bits 15:8
- ADDR_TH1, 8'h8D, SFR address of count bits 23:16

Ports:
- timers_clock_i  in  1  single system clock
- timers_reset_i_b  in  1  synchronous, active-low reset
- timers_sfr_addr_i  in  8  CPU SFR address
- timers_sfr_wr_i  in  1  CPU write strobe, one cycle
- timers_sfr_rd_i  in  1  CPU read strobe, one cycle
- timers_sfr_wdata_i  in  8  CPU write data
- timers_sfr_rdata_o  out  8  read data, registered
- timers_sfr_rhit_o  out  1  rdata valid (address hit), registered
- timers_int1_pin_i  in  1  asynchronous external INT1 pin
- timers_irq_ack_t1_i  in  1  interrupt controller vector acknowledge for Timer 1
- timers_irq_t1_o  out  1  Timer 1 interrupt request (= TF1)
- timers_t1_th1_fb_i / _tm1_fb_i / _tl1_fb_i  in  8 each  core count outputs
- timers_t1_tf1_fb_i  in  1  core TF1 output
- timers_sfr_th1_o / _tm1_o / _tl1_o  out  8 each  count to core inputs, combinational
- timers_sfr_tcon_tf1_o  out  1  TF1 to core, registered
- timers_sfr_tcon_tr1_o  out  1  TR1, registered
- timers_sfr_tmod_gate_t1_o / _m1t1_o / _m0t1_o  out  1 each  TMOD bits 7/5/4, registered
- timers_int1_o  out  1  synchronised INT1 to core

Behaviour:
- Reset (timers_reset_i_b=0 at a clock edge): TF1, TR1, TMOD[7:4], the sync flops, rdata, rhit and shadow all clear to 0. The core clears the count itself, so the count outputs read 0 on the next cycle.
- Count merge (combinational): each byte output equals the corresponding *_fb_i byte, except when wr=1 and the address matches that byte; that byte then takes wdata.
  - The other two bytes still pass their fb values. The core registers the merged value, so a write is visible on fb one cycle later.
  - If the core increments or decrements in the same cycle, it acts on the merged value. Example: write TL1=8'h10 while counting up gives fb TL1=8'h11 next cycle.
- TF1 register, in decreasing priority:
  - core tf1_fb=1 while tf1_q=0 (new overflow) -> 1;
  - CPU write to TCON -> wdata[7];
  - irq_ack=1 -> 0;
  - otherwise -> tf1_fb.
  - An overflow coincident with ack or with a TCON write of 0 is never lost.
  - timers_irq_t1_o = tf1_q, so the request is asserted from the cycle after the overflow edge.
- TR1 <= wdata[6] on a TCON write. TMOD bits 7/5/4 <= wdata[7]/[5]/[4] on a TMOD write. TMOD bit 6 (C/T) is stored and reads back but is not exported.
- INT1: 2-flop synchroniser from pin to timers_int1_o. Latency is 2 clocks; no edge detection.
- Read: on rd=1 with a hit, rdata/rhit register the next edge (1-cycle latency).
  - TCON returns {TF1,TR1,6'b0}; TMOD returns {TMOD[7:4],4'b0}.
  - Count bytes return live fb values.
  - On a miss: rdata=0, rhit=0.
  - Simultaneous rd and wr to the same address returns the pre-write value.
- A wr to an unowned address is ignored.
- Reset mid-count: the next cycle all outputs are at reset values. A pending irq is dropped.

Optional Feature:
- Macro TIMERS_T1_READ_LATCH_EN.
- Defined:
  - A hit read of TL1 also snapshots TM1 and TH1 fb into an 16-bit shadow register.
  - Subsequent reads of TM1/TH1 return the shadow until the next TL1 read.
  - This gives an atomic 24-bit read; the shadow resets to 0.
- Undefined: no shadow register; TM1/TH1 reads are always live.

Test Plan:
- Reset with fb=24'hABCDEF, TF1 previously 1 -> irq=0, TR1=0, rdata=0, rhit=0 the cycle after reset.
- Write TMOD=8'h00, TCON=8'h40, TL1=8'hFE, TM1=8'hFF, TH1=8'hFF (core counting up) -> count wraps to 0, irq=1 one cycle after the core TF1 asserts.
- Hold ack=1 in the same cycle as a second overflow -> TF1 stays 1. Ack on a later idle cycle -> TF1=0 next cycle.
- TMOD=8'h80 (gate), TR1=1, toggle pin 0->1 -> timers_int1_o rises exactly 2 clocks later. Pin low -> count frozen.
- Read TH1 at fb=8'h12 -> rdata=8'h12, rhit=1 one cycle after rd. Read address 8'h90 -> rhit=0, rdata=0.
- With TIMERS_T1_READ_LATCH_EN, counting, read TL1 at count 24'h00FFFF then TM1 after the carry -> TM1 reads 8'hFF. Without the macro -> reads 8'h00.
